// File: rtl/sha256_h123_chain.sv
// SHA-256 chaining/digest words H1..H3 for the three-chunk double hash.
// Supplies per-block initial H values and folds in the round core's a/b/c at block boundaries.
module sha256_h123_chain #(
  parameter logic [31:0] IV1 = 32'h6a09e667,
  parameter logic [31:0] IV2 = 32'hbb67ae85,
  parameter logic [31:0] IV3 = 32'h3c6ef372
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  block,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] c_in,
  output logic [31:0] h1,
  output logic [31:0] h2,
  output logic [31:0] h3,
  output logic [31:0] h1_init,
  output logic [31:0] h2_init,
  output logic [31:0] h3_init,
  output logic        final_valid
);

  typedef enum logic [1:0] {
    BLK_HDR1  = 2'd0,
    BLK_HDR2  = 2'd1,
    BLK_HASH2 = 2'd2,
    BLK_IDLE  = 2'd3
  } block_t;

  localparam logic [31:0] IV [3] = '{IV1, IV2, IV3};

  block_t      block_q;
  block_t      block_n;
  logic [31:0] x     [3];
  logic [31:0] chain [3];
  logic [31:0] dig   [3];

  assign block_n = block_t'(block);
  assign x[0] = a_in;
  assign x[1] = b_in;
  assign x[2] = c_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_q     <= BLK_HDR1;
      final_valid <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        chain[i] <= IV[i];
        dig[i]   <= '0;
      end
    end else begin
      block_q <= block_n;
      if (block_q == BLK_HDR1 && block_n == BLK_HDR2) begin
        final_valid <= 1'b0;
        for (int unsigned i = 0; i < 3; i++) chain[i] <= IV[i] + x[i];
      end else if (block_q == BLK_HDR2 && block_n == BLK_HASH2) begin
        for (int unsigned i = 0; i < 3; i++) dig[i] <= chain[i] + x[i];
      end else if (block_q == BLK_HASH2 &&
                   (block_n == BLK_IDLE || block_n == BLK_HDR1)) begin
        final_valid <= 1'b1;
        for (int unsigned i = 0; i < 3; i++) dig[i] <= IV[i] + x[i];
      end
    end
  end

  // Second header chunk continues from the first chunk's chain; every other block restarts at IV.
  always_comb begin
    h1_init = IV[0];
    h2_init = IV[1];
    h3_init = IV[2];
    if (block_n == BLK_HDR2) begin
      h1_init = chain[0];
      h2_init = chain[1];
      h3_init = chain[2];
    end
  end

  assign h1 = dig[0];
  assign h2 = dig[1];
  assign h3 = dig[2];

endmodule

// File: tb/tb_sha256_h123_chain.sv
// Scoreboard bench for sha256_h123_chain: stimulus pushes expected state, a monitor pops and compares.
module tb_sha256_h123_chain;

  logic        clk;
  logic        rst_n;
  logic [1:0]  block;
  logic [31:0] a_in, b_in, c_in;
  logic [31:0] h1, h2, h3, h1_init, h2_init, h3_init;
  logic        final_valid;

  sha256_h123_chain #(
    .IV1(32'h6a09e667),
    .IV2(32'hbb67ae85),
    .IV3(32'h3c6ef372)
  ) dut (
    .clk(clk), .rst_n(rst_n), .block(block),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .h1(h1), .h2(h2), .h3(h3),
    .h1_init(h1_init), .h2_init(h2_init), .h3_init(h3_init),
    .final_valid(final_valid)
  );

  typedef struct {
    string       name;
    logic [95:0] h;
    logic [95:0] init;
    logic        fv;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [95:0] IVS  = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372};
  localparam logic [95:0] ZERO = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compares the DUT's presented state whenever an expectation is posted.
  initial begin
    exp_t e;
    forever begin
      wait (sb.size() != 0);
      e = sb.pop_front();
      checks++;
      if ({h1, h2, h3} !== e.h || {h1_init, h2_init, h3_init} !== e.init ||
          final_valid !== e.fv) begin
        errors++;
        $display("FAIL %s: got h=%h init=%h fv=%b, expected h=%h init=%h fv=%b",
                 e.name, {h1, h2, h3}, {h1_init, h2_init, h3_init}, final_valid,
                 e.h, e.init, e.fv);
      end
    end
  end

  task automatic post(input string name, input logic [95:0] h,
                      input logic [95:0] init, input logic fv);
    exp_t e;
    e.name = name; e.h = h; e.init = init; e.fv = fv;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] blk, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c);
    @(negedge clk);
    block = blk; a_in = a; b_in = b; c_in = c;
  endtask

  task automatic after_edge(input string name, input logic [95:0] h,
                            input logic [95:0] init, input logic fv);
    @(posedge clk);
    #1;
    post(name, h, init, fv);
  endtask

  initial begin
    rst_n = 1'b0; block = 2'd0; a_in = '0; b_in = '0; c_in = '0;
    #3;
    post("reset", ZERO, IVS, 1'b0);
    #4 rst_n = 1'b1;

    drive(2'd1, 32'd1, 32'd2, 32'd3);
    after_edge("b0to1", ZERO, {32'h6a09e668, 32'hbb67ae87, 32'h3c6ef375}, 1'b0);

    drive(2'd2, 32'hffffffff, 32'h0, 32'h10);
    after_edge("b1to2_wrap", {32'h6a09e667, 32'hbb67ae87, 32'h3c6ef385}, IVS, 1'b0);

    drive(2'd3, 32'h0, 32'h0, 32'h0);
    after_edge("b2to3_final", IVS, IVS, 1'b1);

    drive(2'd0, 32'h55, 32'h66, 32'h77);
    after_edge("b3to0_noop", IVS, IVS, 1'b1);

    drive(2'd1, 32'h100, 32'h200, 32'h300);
    after_edge("b0to1_clear_fv", IVS, {32'h6a09e767, 32'hbb67b085, 32'h3c6ef672}, 1'b0);

    for (int i = 0; i < 10; i++) begin
      drive(2'd1, $urandom, $urandom, $urandom);
      after_edge("hold_blk1", IVS, {32'h6a09e767, 32'hbb67b085, 32'h3c6ef672}, 1'b0);
    end

    drive(2'd2, 32'd1, 32'd1, 32'd1);
    after_edge("b1to2_second", {32'h6a09e768, 32'hbb67b086, 32'h3c6ef673}, IVS, 1'b0);

    drive(2'd0, 32'd5, 32'd6, 32'd7);
    after_edge("b2to0_final", {32'h6a09e66c, 32'hbb67ae8b, 32'h3c6ef379}, IVS, 1'b1);

    drive(2'd3, 32'h9, 32'h9, 32'h9);
    after_edge("b0to3_noop", {32'h6a09e66c, 32'hbb67ae8b, 32'h3c6ef379}, IVS, 1'b1);

    drive(2'd0, 32'h0, 32'h0, 32'h0);
    after_edge("b3to0_idle", {32'h6a09e66c, 32'hbb67ae8b, 32'h3c6ef379}, IVS, 1'b1);

    drive(2'd1, 32'd1, 32'd2, 32'd3);
    after_edge("b0to1_rerun", {32'h6a09e66c, 32'hbb67ae8b, 32'h3c6ef379},
               {32'h6a09e668, 32'hbb67ae87, 32'h3c6ef375}, 1'b0);

    // Asynchronous reset between clock edges while block=1.
    #2 rst_n = 1'b0;
    #1 post("async_reset", ZERO, IVS, 1'b0);

    for (int i = 0; i < 100 && sb.size() != 0; i++) #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
